// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-queue (ALU/MEM) register-file writeback arbiter
// Round-robin drain of per-requester FIFOs into one RF write port, with pending-write lookup.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_reg,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_reg,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  output logic [3:0]  rf_dst_reg,
  output logic [15:0] rf_dst_data,
  output logic        rf_write,
  input  logic [3:0]  query_reg1,
  input  logic [3:0]  query_reg2,
  output logic        query_busy1,
  output logic        query_busy2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // index 0 = ALU queue, index 1 = MEM queue
  logic [3:0]    ent_reg  [2][DEPTH];
  logic [15:0]   ent_data [2][DEPTH];
  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] count    [2];
  logic          last_mem;

  logic          in_valid [2];
  logic [3:0]    in_reg   [2];
  logic [15:0]   in_data  [2];
  logic          ready    [2];
  logic          push     [2];
  logic          pop      [2];
  logic          nonempty [2];
  logic          grant_alu, grant_mem;
  logic          hit1, hit2;
  logic [PW-1:0] offset;

  assign in_valid[0] = alu_valid;
  assign in_reg[0]   = alu_reg;
  assign in_data[0]  = alu_data;
  assign in_valid[1] = mem_valid;
  assign in_reg[1]   = mem_reg;
  assign in_data[1]  = mem_data;

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      ready[q]    = !rst && (count[q] != FULL);
      push[q]     = in_valid[q] && ready[q] && (in_reg[q] != 4'd0);
      nonempty[q] = (count[q] != '0);
    end
  end

  // MEM wins a tie unless it was granted last
  assign grant_mem = nonempty[1] && (!nonempty[0] || !last_mem);
  assign grant_alu = nonempty[0] && !grant_mem;
  assign pop[0]    = grant_alu;
  assign pop[1]    = grant_mem;

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign rf_write  = grant_alu || grant_mem;

  always_comb begin
    rf_dst_reg  = 4'd0;
    rf_dst_data = 16'd0;
    if (grant_mem) begin
      rf_dst_reg  = ent_reg[1][rd_ptr[1]];
      rf_dst_data = ent_data[1][rd_ptr[1]];
    end else if (grant_alu) begin
      rf_dst_reg  = ent_reg[0][rd_ptr[0]];
      rf_dst_data = ent_data[0][rd_ptr[0]];
    end
  end

  // a slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    offset = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset = PW'(i) - rd_ptr[q];
        if ({1'b0, offset} < count[q]) begin
          if (ent_reg[q][i] == query_reg1) hit1 = 1'b1;
          if (ent_reg[q][i] == query_reg2) hit2 = 1'b1;
        end
      end
    end
  end

  assign query_busy1 = hit1 && (query_reg1 != 4'd0);
  assign query_busy2 = hit2 && (query_reg2 != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
      last_mem <= 1'b0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
        if (pop[q])  rd_ptr[q] <= rd_ptr[q] + 1'b1;
        count[q] <= count[q] + CW'(push[q]) - CW'(pop[q]);
      end
      if (rf_write) last_mem <= grant_mem;
    end
  end

  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (push[q]) begin
        ent_reg[q][wr_ptr[q]]  <= in_reg[q];
        ent_data[q][wr_ptr[q]] <= in_data[q];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - queue-model bench for regfile_wb_arbiter
// Directed scenarios with literal expectations, then randomized traffic against the model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_reg = '0, mem_reg = '0, query_reg1 = '0, query_reg2 = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, rf_write, query_busy1, query_busy2;
  logic [3:0]  rf_dst_reg;
  logic [15:0] rf_dst_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [19:0] mq_alu[$];
  logic [19:0] mq_mem[$];
  bit          m_last_mem = 1'b0;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data), .rf_write(rf_write),
    .query_reg1(query_reg1), .query_reg2(query_reg2),
    .query_busy1(query_busy1), .query_busy2(query_busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit model_busy(logic [3:0] r);
    if (r == 4'd0) return 1'b0;
    foreach (mq_alu[i]) if (mq_alu[i][19:16] == r) return 1'b1;
    foreach (mq_mem[i]) if (mq_mem[i][19:16] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(bit av, logic [3:0] ar, logic [15:0] ad,
                       bit mv, logic [3:0] mr, logic [15:0] md,
                       logic [3:0] q1 = 4'd0, logic [3:0] q2 = 4'd0);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    query_reg1 = q1; query_reg2 = q2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
  endtask

  // compare DUT against the queue model, advance the model, move to next negedge
  task automatic check_cycle();
    bit e_ar, e_mr, g_alu, g_mem;
    logic [19:0] head;
    e_ar  = !rst && (mq_alu.size() < DEPTH);
    e_mr  = !rst && (mq_mem.size() < DEPTH);
    g_alu = 1'b0;
    g_mem = 1'b0;
    head  = 20'h0;
    if (!rst) begin
      if (mq_mem.size() > 0 && (mq_alu.size() == 0 || !m_last_mem)) g_mem = 1'b1;
      else if (mq_alu.size() > 0) g_alu = 1'b1;
    end
    if (g_mem) head = mq_mem[0];
    else if (g_alu) head = mq_alu[0];
    chk("alu_ready", alu_ready, e_ar);
    chk("mem_ready", mem_ready, e_mr);
    chk("rf_write", rf_write, g_alu | g_mem);
    chk("rf_dst_reg", rf_dst_reg, head[19:16]);
    chk("rf_dst_data", rf_dst_data, head[15:0]);
    chk("query_busy1", query_busy1, !rst && model_busy(query_reg1));
    chk("query_busy2", query_busy2, !rst && model_busy(query_reg2));
    if (rst) begin
      mq_alu.delete();
      mq_mem.delete();
      m_last_mem = 1'b0;
    end else begin
      if (g_mem) begin void'(mq_mem.pop_front()); m_last_mem = 1'b1; end
      if (g_alu) begin void'(mq_alu.pop_front()); m_last_mem = 1'b0; end
      if (alu_valid && e_ar && alu_reg != 4'd0) mq_alu.push_back({alu_reg, alu_data});
      if (mem_valid && e_mr && mem_reg != 4'd0) mq_mem.push_back({mem_reg, mem_data});
    end
    @(negedge clk);
  endtask

  // reset pulse that starts and ends between two rising edges
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_rf_dst_reg", rf_dst_reg, 4'd0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b0);
    mq_alu.delete();
    mq_mem.delete();
    m_last_mem = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    @(negedge clk);
    idle();
    chk("reset_alu_ready", alu_ready, 1'b0);
    chk("reset_rf_write", rf_write, 1'b0);
    check_cycle();
    rst = 1'b0;
    idle();
    chk("post_reset_alu_ready", alu_ready, 1'b1);
    chk("post_reset_mem_ready", mem_ready, 1'b1);
    check_cycle();

    // single write
    drive(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'd0);
    check_cycle();
    idle();
    chk("single_write", rf_write, 1'b1);
    chk("single_reg", rf_dst_reg, 4'd5);
    chk("single_data", rf_dst_data, 16'h1234);
    check_cycle();
    idle();
    chk("single_done", rf_write, 1'b0);
    check_cycle();

    // tie after reset: MEM first
    pulse_reset();
    drive(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd4, 16'hBBBB);
    check_cycle();
    idle();
    chk("tie_first_reg", rf_dst_reg, 4'd4);
    chk("tie_first_data", rf_dst_data, 16'hBBBB);
    check_cycle();
    idle();
    chk("tie_second_reg", rf_dst_reg, 4'd3);
    chk("tie_second_data", rf_dst_data, 16'hAAAA);
    check_cycle();

    // register 0 is dropped
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0);
    check_cycle();
    idle();
    chk("r0_no_write", rf_write, 1'b0);
    chk("r0_busy1", query_busy1, 1'b0);
    check_cycle();

    // full ALU queue stalls, order 1,2,3 preserved
    pulse_reset();
    drive(1'b1, 4'd1, 16'h0001, 1'b1, 4'd9, 16'h0009);
    check_cycle();
    drive(1'b1, 4'd2, 16'h0002, 1'b1, 4'd10, 16'h000A);
    check_cycle();
    drive(1'b1, 4'd3, 16'h0003, 1'b0, 4'd0, 16'd0);
    chk("full_alu_ready", alu_ready, 1'b0);
    chk("full_write_1", rf_dst_reg, 4'd1);
    check_cycle();
    drive(1'b1, 4'd3, 16'h0003, 1'b0, 4'd0, 16'd0);
    chk("full_ready_back", alu_ready, 1'b1);
    chk("full_write_mem", rf_dst_reg, 4'd10);
    check_cycle();
    idle();
    chk("full_write_2", rf_dst_reg, 4'd2);
    check_cycle();
    idle();
    chk("full_write_3", rf_dst_reg, 4'd3);
    chk("full_write_3_data", rf_dst_data, 16'h0003);
    check_cycle();

    // pending-write lookup
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd2, 16'h1111, 4'd0, 4'd7);
    check_cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h0042, 4'd0, 4'd7);
    chk("busy2_not_yet", query_busy2, 1'b0);
    check_cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd7);
    chk("busy2_while_popping", query_busy2, 1'b1);
    chk("busy2_write_reg", rf_dst_reg, 4'd7);
    chk("busy2_write_data", rf_dst_data, 16'h0042);
    check_cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0, 4'd7);
    chk("busy2_cleared", query_busy2, 1'b0);
    check_cycle();

    // reset mid-run drops pending writes
    drive(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202);
    check_cycle();
    drive(1'b1, 4'd3, 16'h0303, 1'b1, 4'd4, 16'h0404);
    check_cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h0505);
    check_cycle();
    pulse_reset();
    idle();
    chk("after_rst_no_write", rf_write, 1'b0);
    chk("after_rst_alu_ready", alu_ready, 1'b1);
    chk("after_rst_mem_ready", mem_ready, 1'b1);
    check_cycle();
    idle();
    chk("after_rst_still_idle", rf_write, 1'b0);
    check_cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
